// File: rtl/md_hilo_ctrl.sv
// md_hilo_ctrl: HI/LO owner and mul/div engine sequencer; MD_FASTMUL_EN computes MULT/MULTU in-block
module md_hilo_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] rd_data_o,
  output logic        eng_start_o,
  output logic [1:0]  eng_sel_o,
  output logic [31:0] eng_a_o,
  output logic [31:0] eng_b_o,
  input  logic        eng_done_i,
  input  logic [31:0] eng_hi_i,
  input  logic [31:0] eng_lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div0_o,
  output logic        err_o
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_e;
  state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] hi_q, lo_q, a_q, b_q;
  logic [1:0] sel_q;
  logic start_q, div0_q, err_q;
  logic is_div, rt_zero, use_eng, idle_issue, accept;
  assign is_div     = op_i[2:1] == 2'b01;
  assign rt_zero    = rt_i == 32'd0;
  assign idle_issue = state_q == S_IDLE && issue_i && !flush_i;
`ifdef MD_FASTMUL_EN
  logic is_mul;
  logic [63:0] prod;
  assign is_mul  = op_i[2:1] == 2'b00;
  assign prod    = {{32{~op_i[0] & rs_i[31]}}, rs_i} * {{32{~op_i[0] & rt_i[31]}}, rt_i};
  assign use_eng = is_div;
`else
  assign use_eng = !op_i[2];
`endif
  assign accept      = idle_issue && use_eng && !(is_div && rt_zero);
  assign stall_o     = !flush_i && (accept || state_q == S_START || state_q == S_WAIT);
  assign rd_data_o   = op_i == 3'b110 ? hi_q : op_i == 3'b111 ? lo_q : 32'd0;
  assign eng_start_o = start_q;
  assign eng_sel_o   = sel_q;
  assign eng_a_o     = a_q;
  assign eng_b_o     = b_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign div0_o      = div0_q;
  assign err_o       = err_q;
  // Sequencer: accept ops, run the engine handshake with timeout, own HI/LO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      start_q <= 1'b0;
      div0_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      div0_q  <= 1'b0;
      err_q   <= 1'b0;
      if (flush_i) state_q <= S_IDLE;
      else case (state_q)
        S_IDLE: if (issue_i) begin
          if (accept) begin
            a_q     <= rs_i;
            b_q     <= rt_i;
            sel_q   <= op_i[1:0];
            start_q <= 1'b1;
            state_q <= S_START;
          end
          if (is_div && rt_zero) div0_q <= 1'b1;
          if (op_i == 3'b100) hi_q <= rs_i;
          if (op_i == 3'b101) lo_q <= rs_i;
`ifdef MD_FASTMUL_EN
          if (is_mul) {hi_q, lo_q} <= prod;
`endif
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: if (eng_done_i) begin
          hi_q    <= eng_hi_i;
          lo_q    <= eng_lo_i;
          state_q <= S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_q   <= 1'b1;
          state_q <= S_DONE;
        end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_hilo_ctrl.sv
// tb_md_hilo_ctrl: randomized bench with a cycle-level behavioural model of md_hilo_ctrl
module tb_md_hilo_ctrl;
  localparam int TIMEOUT = 64;
  logic clk = 0, rst_n = 0, issue = 0, flush = 0;
  logic [2:0] op = 0;
  logic [31:0] rs = 0, rt = 0;
  logic stall, eng_start, div0, err;
  logic [31:0] rd_data, eng_a, eng_b, hi, lo;
  logic [1:0] eng_sel;
  logic eng_done = 0;
  logic [31:0] eng_hi = 0, eng_lo = 0;
  int n_cmp = 0, n_bad = 0;
  int eng_lat = 5;
  int n_start = 0, n_div0 = 0, n_err = 0;

  md_hilo_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk_i(clk), .rst_ni(rst_n), .issue_i(issue), .op_i(op), .rs_i(rs), .rt_i(rt),
    .flush_i(flush), .stall_o(stall), .rd_data_o(rd_data), .eng_start_o(eng_start),
    .eng_sel_o(eng_sel), .eng_a_o(eng_a), .eng_b_o(eng_b), .eng_done_i(eng_done),
    .eng_hi_i(eng_hi), .eng_lo_i(eng_lo), .hi_o(hi), .lo_o(lo), .div0_o(div0), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // Iterative engine stand-in: computes the true result, answers eng_lat cycles after start (0 = never)
  logic es;
  logic [31:0] sa, sb, eh, el;
  logic [1:0] ss;
  longint x, y, q, r;
  int pend = 0;
  always @(posedge clk) begin
    es = eng_start; sa = eng_a; sb = eng_b; ss = eng_sel;
    #1;
    eng_done = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) eng_done = 1;
    end
    if (es && eng_lat > 0) begin
      if (ss[0]) begin x = longint'({32'd0, sa}); y = longint'({32'd0, sb}); end
      else begin x = $signed(sa); y = $signed(sb); end
      if (ss[1]) begin q = x / y; r = x % y; eh = r[31:0]; el = q[31:0]; end
      else begin q = x * y; eh = q[63:32]; el = q[31:0]; end
      pend = eng_lat - 1;
      if (pend == 0) eng_done = 1;
    end
    eng_hi = eh;
    eng_lo = el;
  end

  // Pulse counters used by the directed checks
  always @(negedge clk) begin
    if (eng_start) n_start++;
    if (div0) n_div0++;
    if (err) n_err++;
  end

  // Reference model: an op in flight has an age (1 = start cycle, k>=2 = (k-1)th waiting cycle)
  logic [31:0] m_hi = 0, m_lo = 0, m_a = 0, m_b = 0;
  logic [1:0] m_sel = 0;
  bit m_inf = 0, m_fin = 0, m_d0 = 0, m_er = 0, p_d0, p_er, m_eng, m_stall;
  int m_age = 0;
  longint px, py, pp;
  always begin
    @(posedge clk);
    p_d0 = 0; p_er = 0;
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_sel = 0; m_inf = 0; m_fin = 0;
    end else if (flush) begin
      m_inf = 0; m_fin = 0;
    end else if (m_fin) m_fin = 0;
    else if (m_inf) begin
      if (m_age >= 2 && eng_done) begin
        m_hi = eng_hi; m_lo = eng_lo; m_inf = 0; m_fin = 1;
      end else if (m_age - 1 == TIMEOUT) begin
        p_er = 1; m_inf = 0; m_fin = 1;
      end else m_age++;
    end else if (issue) begin
      if (op == 3'd4) m_hi = rs;
      else if (op == 3'd5) m_lo = rs;
      else if (op < 3'd4 && op[1] && rt == 0) p_d0 = 1;
`ifdef MD_FASTMUL_EN
      else if (op < 3'd2) begin
        if (op[0]) begin px = longint'({32'd0, rs}); py = longint'({32'd0, rt}); end
        else begin px = $signed(rs); py = $signed(rt); end
        pp = px * py;
        m_hi = pp[63:32]; m_lo = pp[31:0];
      end
`endif
      else if (op < 3'd4) begin
        m_inf = 1; m_age = 1; m_a = rs; m_b = rt; m_sel = op[1:0];
      end
    end
    m_d0 = p_d0; m_er = p_er;
    @(negedge clk);
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_sel = 0; m_inf = 0; m_fin = 0; m_d0 = 0; m_er = 0;
    end
`ifdef MD_FASTMUL_EN
    m_eng = op[2:1] == 2'b01;
`else
    m_eng = !op[2];
`endif
    m_stall = !flush && (m_inf || (!m_fin && issue && m_eng && !(op[1] && rt == 0)));
    chk("stall", 32'(stall), 32'(m_stall));
    chk("eng_start", 32'(eng_start), 32'(m_inf && m_age == 1));
    chk("eng_sel", 32'(eng_sel), 32'(m_sel));
    chk("eng_a", eng_a, m_a);
    chk("eng_b", eng_b, m_b);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("rd_data", rd_data, op == 3'd6 ? m_hi : op == 3'd7 ? m_lo : 32'd0);
    chk("div0", 32'(div0), 32'(m_d0));
    chk("err", 32'(err), 32'(m_er));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int fat, output int ns);
    issue = 1; op = o; rs = a; rt = b; ns = 0;
    for (int k = 0; k < 200; k++) begin
      flush = (k == fat);
      @(negedge clk);
      if (stall) ns++;
      else begin
        cyc();
        issue = 0; flush = 0;
        return;
      end
      cyc();
    end
    chk("run_op_timeout", 32'd1, 32'd0);
    issue = 0; flush = 0;
  endtask

  int ns, s0, d0, e0, gap;
  logic [2:0] t5op;
  initial begin
    cyc(); cyc();
    @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    #1 rst_n = 1;
    cyc();
    // 1: DIVU interrupted by reset, then rerun
    eng_lat = 33;
    issue = 1; op = 3'd3; rs = 100; rt = 7;
    repeat (12) cyc();
    rst_n = 0; issue = 0;
    @(negedge clk);
    chk("t1_rst_hi", hi, 32'd0);
    chk("t1_rst_lo", lo, 32'd0);
    chk("t1_rst_stall", 32'(stall), 32'd0);
    chk("t1_rst_start", 32'(eng_start), 32'd0);
    cyc(); cyc();
    rst_n = 1;
    repeat (40) cyc();
    chk("t1_late_hi", hi, 32'd0);
    chk("t1_late_lo", lo, 32'd0);
    s0 = n_start;
    run_op(3'd3, 100, 7, -1, ns);
    chk("t1_stall_cycles", ns, 35);
    chk("t1_starts", n_start - s0, 1);
    chk("t1_sel", 32'(eng_sel), 32'd3);
    chk("t1_hi", hi, 32'd2);
    chk("t1_lo", lo, 32'd14);
    // 2: signed DIV
    eng_lat = 5;
    run_op(3'd2, 32'hFFFFFFF9, 2, -1, ns);
    chk("t2_stall_cycles", ns, 7);
    chk("t2_sel", 32'(eng_sel), 32'd2);
    chk("t2_a", eng_a, 32'hFFFFFFF9);
    chk("t2_hi", hi, 32'hFFFFFFFF);
    chk("t2_lo", lo, 32'hFFFFFFFD);
    // 3: divide by zero
    run_op(3'd4, 32'h11, 0, -1, ns);
    run_op(3'd5, 32'h22, 0, -1, ns);
    s0 = n_start; d0 = n_div0;
    run_op(3'd2, 32'h55, 0, -1, ns);
    cyc(); cyc();
    chk("t3_stall_cycles", ns, 0);
    chk("t3_starts", n_start - s0, 0);
    chk("t3_div0", n_div0 - d0, 1);
    chk("t3_hi", hi, 32'h11);
    chk("t3_lo", lo, 32'h22);
    // 4: moves to and from HI/LO
    run_op(3'd4, 32'hDEADBEEF, 0, -1, ns);
    run_op(3'd5, 32'h12345678, 0, -1, ns);
    issue = 1; op = 3'd7;
    @(negedge clk);
    chk("t4_rd", rd_data, 32'h12345678);
    chk("t4_stall", 32'(stall), 32'd0);
    chk("t4_hi", hi, 32'hDEADBEEF);
    cyc();
    issue = 0;
    // 5: flush in the third waiting cycle, engine answers later
    eng_lat = 10;
`ifdef MD_FASTMUL_EN
    t5op = 3'd3;
`else
    t5op = 3'd1;
`endif
    run_op(t5op, 32'hFFFFFFFF, 2, 4, ns);
    @(negedge clk);
    chk("t5_stall_after", 32'(stall), 32'd0);
    chk("t5_stall_cycles", ns, 4);
    repeat (15) cyc();
    chk("t5_hi", hi, 32'hDEADBEEF);
    chk("t5_lo", lo, 32'h12345678);
    // 6: timeout, or in-block multiply
`ifdef MD_FASTMUL_EN
    run_op(3'd0, 32'hFFFFFFFF, 3, -1, ns);
    chk("t6_stall_cycles", ns, 0);
    chk("t6_hi", hi, 32'hFFFFFFFF);
    chk("t6_lo", lo, 32'hFFFFFFFD);
`else
    eng_lat = 0;
    e0 = n_err;
    run_op(3'd0, 5, 6, -1, ns);
    cyc();
    chk("t6_stall_cycles", ns, TIMEOUT + 2);
    chk("t6_err", n_err - e0, 1);
    chk("t6_hi", hi, 32'hDEADBEEF);
    chk("t6_lo", lo, 32'h12345678);
`endif
    // Random traffic against the model
    for (int i = 0; i < 250; i++) begin
      eng_lat = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 20);
      run_op(3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom,
             ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8) : -1, ns);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        op = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 40) == 0) rst_n = 0;
        cyc();
        rst_n = 1;
      end
    end
    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
